// File: rtl/cdb_arbiter_if.sv
// Result/CDB bundle between the integer functional units and the CDB arbiter.
// Ports: src_* result pulses in, src_stall hints out, cdb_* lanes and overflow_err out.
interface cdb_arbiter_if #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_SRC       = 4,
    parameter int CDB_WIDTH     = 2
);
    localparam int PREG_BITS = $clog2(NUM_PHYS_REGS);

    logic [NUM_SRC-1:0]                    src_valid;
    logic [NUM_SRC-1:0][PREG_BITS-1:0]     src_prd;
    logic [NUM_SRC-1:0][31:0]              src_data;
    logic [NUM_SRC-1:0][6:0]               src_rob_idx;
    logic [NUM_SRC-1:0]                    src_stall;

    logic [CDB_WIDTH-1:0]                  cdb_valid;
    logic [CDB_WIDTH-1:0][PREG_BITS-1:0]   cdb_prd;
    logic [CDB_WIDTH-1:0][31:0]            cdb_data;
    logic [CDB_WIDTH-1:0][6:0]             cdb_rob_idx;
    logic                                  overflow_err;

    // Producer / consumer side: drives results, observes the bus.
    modport master (
        output src_valid, src_prd, src_data, src_rob_idx,
        input  src_stall,
        input  cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, overflow_err
    );

    // Arbiter side.
    modport slave (
        input  src_valid, src_prd, src_data, src_rob_idx,
        output src_stall,
        output cdb_valid, cdb_prd, cdb_data, cdb_rob_idx, overflow_err
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs, round-robin grant of up to
// CDB_WIDTH results per cycle onto a registered CDB, per-source stall hints.
// Ports: clk, rst (sync, active-high), flush (sync), bus (cdb_arbiter_if.slave).
module cdb_arbiter #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_SRC       = 4,
    parameter int CDB_WIDTH     = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int STALL_MARGIN  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    cdb_arbiter_if.slave        bus
);
    localparam int PB = $clog2(NUM_PHYS_REGS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [PB-1:0] prd;
        logic [31:0]   data;
        logic [6:0]    rob_idx;
    } entry_t;

    // Storage and state
    entry_t        mem   [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0] head  [NUM_SRC];
    logic [AW-1:0] tail  [NUM_SRC];
    logic [AW:0]   count [NUM_SRC];
    logic [SW-1:0] rr_ptr;

    // Per-source combinational views
    entry_t             in_e   [NUM_SRC];
    entry_t             cand_e [NUM_SRC];
    logic [NUM_SRC-1:0] has_head;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] drop;

    // Lane results of this cycle's grant
    entry_t               lane_e [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] lane_v;
    logic [SW-1:0]        rr_next;

    // Candidate per source: FIFO head if any, else the incoming result.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_e[i]     = {bus.src_prd[i], bus.src_data[i], bus.src_rob_idx[i]};
            has_head[i] = (count[i] != '0);
            cand[i]     = has_head[i] | bus.src_valid[i];
            cand_e[i]   = has_head[i] ? mem[i][head[i]] : in_e[i];
        end
    end

    // Round-robin scan starting at rr_ptr; grants fill lanes in scan order.
    always_comb begin
        int idx;
        int n;
        grant   = '0;
        lane_v  = '0;
        rr_next = rr_ptr;
        idx     = 0;
        n       = 0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            lane_e[l] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (cand[idx] && (n < CDB_WIDTH)) begin
                grant[idx] = 1'b1;
                lane_v[n]  = 1'b1;
                lane_e[n]  = cand_e[idx];
                n          = n + 1;
                if (idx == NUM_SRC - 1) begin
                    rr_next = '0;
                end else begin
                    rr_next = SW'(idx + 1);
                end
            end
        end
    end

    // FIFO control. A granted empty-FIFO source bypasses, so it never pushes;
    // a full FIFO without a pop drops its incoming result.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]  = grant[i] & has_head[i];
            drop[i] = bus.src_valid[i] & (count[i] == FULL) & ~pop[i];
            push[i] = bus.src_valid[i]
                    & ~(grant[i] & ~has_head[i])
                    & ~drop[i];
        end
    end

    // Stall hint from registered occupancy.
    always_comb begin
        bus.src_stall = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_stall[i] =
                ((FIFO_DEPTH - int'(count[i])) <= STALL_MARGIN);
        end
    end

    // FIFO payload storage; needs no reset since count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst && !flush && push[i]) begin
                mem[i][tail[i]] <= in_e[i];
            end
        end
    end

    // Pointers, counts, round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                head[i]  <= head[i] + AW'(pop[i]);
                tail[i]  <= tail[i] + AW'(push[i]);
                count[i] <= count[i]
                          + (AW+1)'(push[i])
                          - (AW+1)'(pop[i]);
            end
            rr_ptr <= rr_next;
        end
    end

    // Registered CDB lanes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bus.cdb_valid <= '0;
            for (int l = 0; l < CDB_WIDTH; l++) begin
                bus.cdb_prd[l]     <= '0;
                bus.cdb_data[l]    <= '0;
                bus.cdb_rob_idx[l] <= '0;
            end
        end else begin
            bus.cdb_valid <= lane_v;
            for (int l = 0; l < CDB_WIDTH; l++) begin
                bus.cdb_prd[l]     <= lane_e[l].prd;
                bus.cdb_data[l]    <= lane_e[l].data;
                bus.cdb_rob_idx[l] <= lane_e[l].rob_idx;
            end
        end
    end

    // Sticky drop indicator; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow_err <= 1'b0;
        end else if (!flush && (|drop)) begin
            bus.overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 2-lane instance and a 1-lane instance.
// Checks latency, round-robin order, fill/stall, overflow, flush and reset.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic flush_a;
    logic flush_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.CDB_WIDTH(2)) ifa ();
    cdb_arbiter_if #(.CDB_WIDTH(1)) ifb ();

    cdb_arbiter #(.CDB_WIDTH(2)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_a),
        .bus   (ifa)
    );

    cdb_arbiter #(.CDB_WIDTH(1)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_b),
        .bus   (ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source i, cycle k: data = base + i, prd = i+10, rob = i+20
    task automatic drive_a(input logic [3:0] v, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            ifa.src_valid[i]   = v[i];
            ifa.src_data[i]    = base + 32'(i);
            ifa.src_prd[i]     = 6'(i + 10);
            ifa.src_rob_idx[i] = 7'(i + 20);
        end
    endtask

    // Source i, cycle k: data = (i << 8) | k
    task automatic drive_b(input logic [3:0] v, input int k);
        for (int i = 0; i < 4; i++) begin
            ifb.src_valid[i]   = v[i];
            ifb.src_data[i]    = 32'((i << 8) | k);
            ifb.src_prd[i]     = 6'(i);
            ifb.src_rob_idx[i] = 7'(k);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_a(4'h0, 32'h0);
        drive_b(4'h0, 0);
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] fair_exp [12];
    logic [31:0] fill_exp [7];
    logic [3:0]  fill_stall [7];
    logic [31:0] e_data;

    initial begin
        fair_exp = '{32'h000, 32'h100, 32'h001, 32'h101,
                     32'h002, 32'h102, 32'h003, 32'h103,
                     32'h004, 32'h104, 32'h005, 32'h105};
        fill_exp = '{32'h200, 32'h300, 32'h201, 32'h301,
                     32'h202, 32'h302, 32'h203};
        fill_stall = '{4'h0, 4'h0, 4'h8, 4'hC, 4'h8, 4'h8, 4'h8};

        flush_a = 1'b0;
        flush_b = 1'b0;
        rst     = 1'b1;
        drive_a(4'h0, 32'h0);
        drive_b(4'h0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid_a", ifa.cdb_valid, 2'b00);
        chk("rst_data_a", ifa.cdb_data[0], 32'h0);
        chk("rst_ovf_a", ifa.overflow_err, 1'b0);
        chk("rst_stall_a", ifa.src_stall, 4'h0);
        chk("rst_rr_a", dut_a.rr_ptr, 2'd0);
        chk("rst_valid_b", ifb.cdb_valid, 1'b0);

        // Single result, 1-cycle latency on lane 0
        drive_a(4'h1, 32'h0);
        ifa.src_prd[0]     = 6'd5;
        ifa.src_data[0]    = 32'h1234;
        ifa.src_rob_idx[0] = 7'd9;
        tick();
        chk("single_valid", ifa.cdb_valid, 2'b01);
        chk("single_prd", ifa.cdb_prd[0], 6'd5);
        chk("single_data", ifa.cdb_data[0], 32'h1234);
        chk("single_rob", ifa.cdb_rob_idx[0], 7'd9);
        chk("single_l1_data", ifa.cdb_data[1], 32'h0);
        chk("single_rr", dut_a.rr_ptr, 2'd1);
        drive_a(4'h0, 32'h0);
        tick();
        chk("single_idle", ifa.cdb_valid, 2'b00);

        // Flush with empty FIFOs returns rr_ptr to 0
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        chk("flush0_rr", dut_a.rr_ptr, 2'd0);

        // Four simultaneous results over two cycles
        drive_a(4'hF, 32'hA0);
        tick();
        drive_a(4'h0, 32'h0);
        chk("four_c1_valid", ifa.cdb_valid, 2'b11);
        chk("four_c1_l0", ifa.cdb_data[0], 32'hA0);
        chk("four_c1_l1", ifa.cdb_data[1], 32'hA1);
        chk("four_c1_rr", dut_a.rr_ptr, 2'd2);
        tick();
        chk("four_c2_valid", ifa.cdb_valid, 2'b11);
        chk("four_c2_l0", ifa.cdb_data[0], 32'hA2);
        chk("four_c2_l1", ifa.cdb_data[1], 32'hA3);
        chk("four_c2_prd1", ifa.cdb_prd[1], 6'd13);
        chk("four_c2_rr", dut_a.rr_ptr, 2'd0);
        chk("four_ovf", ifa.overflow_err, 1'b0);
        tick();
        chk("four_idle", ifa.cdb_valid, 2'b00);

        // Flush with three buffered results and one incoming
        drive_a(4'hF, 32'hC0);
        tick();
        chk("fl_c0_l0", ifa.cdb_data[0], 32'hC0);
        chk("fl_c0_l1", ifa.cdb_data[1], 32'hC1);
        drive_a(4'h7, 32'hD0);
        tick();
        chk("fl_c1_l0", ifa.cdb_data[0], 32'hC2);
        chk("fl_c1_l1", ifa.cdb_data[1], 32'hC3);
        drive_a(4'h8, 32'hE0);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        drive_a(4'h0, 32'h0);
        chk("fl_valid", ifa.cdb_valid, 2'b00);
        chk("fl_rr", dut_a.rr_ptr, 2'd0);
        chk("fl_stall", ifa.src_stall, 4'h0);
        tick();
        chk("fl_after_valid", ifa.cdb_valid, 2'b00);
        drive_a(4'h2, 32'hF0);
        tick();
        drive_a(4'h0, 32'h0);
        chk("fl_new_valid", ifa.cdb_valid, 2'b01);
        chk("fl_new_data", ifa.cdb_data[0], 32'hF1);
        chk("fl_new_rr", dut_a.rr_ptr, 2'd2);
        tick();
        chk("fl_new_idle", ifa.cdb_valid, 2'b00);

        // Fairness, one lane: sources 0 and 1 every cycle
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive_b((k < 6) ? 4'h3 : 4'h0, k);
            tick();
            chk("fair_valid", ifb.cdb_valid, 1'b1);
            chk("fair_data", ifb.cdb_data[0], fair_exp[k]);
            if (k == 2) chk("fair_stall2", ifb.src_stall, 4'h2);
            if (k == 3) chk("fair_stall3", ifb.src_stall, 4'h3);
        end
        drive_b(4'h0, 0);
        tick();
        chk("fair_drained", ifb.cdb_valid, 1'b0);

        // Order/fill: source 3 saturated, source 2 bursts four results
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive_b({1'b1, (k < 4), 2'b00}, k);
            tick();
            chk("fill_data", ifb.cdb_data[0], fill_exp[k]);
            chk("fill_stall", ifb.src_stall, fill_stall[k]);
        end
        chk("fill_ovf", ifb.overflow_err, 1'b0);

        // Reset mid-stream discards buffered source 3 results
        do_reset();
        chk("mid_rst_valid", ifb.cdb_valid, 1'b0);
        tick();
        chk("mid_rst_idle", ifb.cdb_valid, 1'b0);

        // Overflow: all sources saturated; item 5 of sources 2/3 dropped
        for (int k = 0; k < 23; k++) begin
            drive_b((k < 6) ? 4'hF : 4'h0, k);
            tick();
            e_data = 32'(((k % 4) << 8) | (k / 4));
            if (k < 22) begin
                chk("ovf_valid", ifb.cdb_valid, 1'b1);
                chk("ovf_data", ifb.cdb_data[0], e_data);
            end else begin
                chk("ovf_no_dropped", ifb.cdb_valid, 1'b0);
            end
            if (k == 0) chk("ovf_stall0", ifb.src_stall, 4'h0);
            if (k == 1) chk("ovf_stall1", ifb.src_stall, 4'hC);
            if (k == 4) chk("ovf_err_pre", ifb.overflow_err, 1'b0);
            if (k == 5) chk("ovf_err_set", ifb.overflow_err, 1'b1);
        end

        // Sticky through flush, cleared by reset
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        chk("ovf_after_flush", ifb.overflow_err, 1'b1);
        chk("ovf_flush_valid", ifb.cdb_valid, 1'b0);
        do_reset();
        chk("ovf_after_rst", ifb.overflow_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Consumer end of the integer functional-unit result interface. Accepts per-cycle result pulses from NUM_SRC producers (ALU0, ALU1, MUL, DIV, in that index order). Each source has a small FIFO. Every cycle, up to CDB_WIDTH results are granted round-robin onto the registered common data bus, which feeds the ROB, the issue-queue wakeup logic and the PRF write ports. Producers have no backpressure, so the block exports per-source stall hints to the issue unit.

Parameters:
NUM_PHYS_REGS, 64, physical register count; PREG_BITS = $clog2(NUM_PHYS_REGS)
NUM_SRC, 4, number of result producers
CDB_WIDTH, 2, broadcast lanes per cycle
FIFO_DEPTH, 4, entries per source FIFO (power of 2, >=2)
STALL_MARGIN, 2, free-entry threshold for src_stall

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  pipeline flush (synchronous)
src_valid  in  [NUM_SRC]  result pulse per source
src_prd  in  PREG_BITS x NUM_SRC  destination physical reg
src_data  in  32 x NUM_SRC  result value
src_rob_idx  in  7 x NUM_SRC  ROB index
src_stall  out  [NUM_SRC]  issue-throttle hint per source
cdb_valid  out  [CDB_WIDTH]  lane valid
cdb_prd  out  PREG_BITS x CDB_WIDTH  lane destination
cdb_data  out  32 x CDB_WIDTH  lane value
cdb_rob_idx  out  7 x CDB_WIDTH  lane ROB index
overflow_err  out  1  sticky: a result was dropped

Behaviour:
- Reset (rst=1 at edge): all FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_prd/data/rob_idx=0, overflow_err=0, src_stall=0 (combinational from counts).
- Candidate per source i: FIFO head if count_i>0; else incoming src_*[i] if src_valid[i]; else none. Only the head is ever a candidate, so per-source order is preserved.
- Grant: scan sources from rr_ptr upward, modulo NUM_SRC. The first min(CDB_WIDTH, #candidates) candidates are granted. Grants go to lanes 0,1,... in scan order. Unused lanes get cdb_valid=0; their payload is don't-care but held at 0.
- cdb_* are registered: a grant at cycle t appears on the CDB in cycle t+1. Uncontended latency from src_valid to cdb_valid is 1 cycle.
- Granted head: dequeued. If src_valid[i] is also high the same cycle, the incoming result is enqueued, giving a simultaneous push and pop with count unchanged.
- Granted incoming (FIFO was empty): bypasses the FIFO and is not enqueued.
- Ungranted incoming: enqueued at the tail.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted source + 1) mod NUM_SRC; otherwise rr_ptr is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH, stored in $clog2(FIFO_DEPTH)+1 bits.
- src_stall[i] = (FIFO_DEPTH - count_i) <= STALL_MARGIN, computed from the registered count.
- Overflow: count_i == FIFO_DEPTH, src_valid[i]=1 and no pop this cycle. The incoming result is dropped, FIFO contents are unchanged, and overflow_err is set. overflow_err clears only on rst, not on flush.
- Flush (rst=0, flush=1): all FIFOs emptied, rr_ptr=0, cdb_valid=0 next cycle. src_* inputs in the flush cycle are discarded (no enqueue, no grant). The cycle after flush behaves normally.
- rst has priority over flush. rst mid-stream discards all buffered results.
- No duplicate, loss or reordering within a source, except on overflow or flush.

Test Plan:
- Single result: ALU0 src_valid=1, prd=5, data=0x1234, rob=9 at cycle 0 -> cycle 1 lane0 valid, prd=5, data=0x1234, rob=9; lane1 invalid; rr_ptr=1.
- Four simultaneous results (sources 0-3, data=0xA0..0xA3), rr_ptr=0 -> cycle 1 lanes carry 0xA0, 0xA1; cycle 2 carry 0xA2, 0xA3; no overflow; rr_ptr=0 after.
- Fairness: sources 0 and 1 valid every cycle with CDB_WIDTH=1 -> CDB alternates src0, src1, src0, ... and src_stall rises on the backlogged source as its FIFO fills.
- Order/fill: with CDB_WIDTH forced 1 and source 3 saturated, source 2 sends 0x10..0x13 on 4 consecutive cycles -> src_stall[2] asserts when count>=2; outputs 0x10..0x13 in order; overflow_err=0.
- Overflow: source 2 sends a 5th result while count=4 and ungranted -> that data never appears; overflow_err=1 and stays 1 through a later flush; cleared by rst.
- Flush: 3 results buffered plus a new src_valid in the flush cycle -> next cycle cdb_valid=0 and all counts 0; a result issued 2 cycles after flush appears 1 cycle later on lane0.
